game_state_ctrl: RTL and testbench
==================================

// Module: game_state_ctrl
// PURPOSE
//  Top-level game sequencer for the Pac-Man playfield. Sits upstream of ball: drives the 2-bit state
//  bus that gates pacman/ghost motion. Consumes ball's caught_check and game_over_check.
//  Tracks lives, runs the post-catch freeze timer and issues a registered round_reset pulse.
//  Top level ORs round_reset with Reset into ball's Reset.
// PARAMETERS
//  LIVES_INIT     3      lives loaded at reset / new game (1..3)
//  CAUGHT_FRAMES  120    frames frozen after a catch (2 s at 60 Hz), >=2
//  START_KEY      8'h2C  USB HID keycode (space) that starts / restarts a game
// PORTS
//  frame_clk        in   1  vsync-rate clock, all logic on posedge
//  Reset            in   1  asynchronous, active-high
//  keycode          in   8  current USB keycode, 8'h00 = none
//  caught_check     in   1  any ghost overlaps pacman (level, from ball)
//  game_over_check  in   1  all pellets eaten (level, from ball)
//  state            out  2  0=START 1=PLAY 2=CAUGHT 3=OVER (to ball, ghosts, color mapper)
//  lives            out  2  remaining lives, shown by HUD
//  round_reset      out  1  one-frame pulse: repositions pacman/ghosts, reloads pellets on new game
//  win              out  1  1 when OVER was reached via game_over_check
// BEHAVIOUR
//  Reset: state=START, lives=LIVES_INIT, round_reset=0, win=0, timer=0, key_prev=8'h00.
//  key_hit = (keycode==START_KEY) && (key_prev!=START_KEY); key_prev <= keycode every frame.
//   Holding the key yields exactly one key_hit; must release and press again.
//  round_reset is registered: high for exactly one frame; 0 in every other frame.
//  All transitions take effect on the frame_clk edge where the condition is sampled (latency 1).
//  START: key_hit -> PLAY. caught_check/game_over_check ignored.
//  PLAY (checks in priority order):
//   1. round_reset==1 this frame: guard frame, caught_check and game_over_check ignored.
//   2. game_over_check -> OVER, win<=1 (beats a simultaneous catch; lives unchanged).
//   3. caught_check && lives==1 -> OVER, lives<=0, win<=0.
//   4. caught_check && lives>1 -> CAUGHT, lives<=lives-1, timer<=CAUGHT_FRAMES-1.
//   keycode otherwise ignored in PLAY (movement keys belong to ball).
//  CAUGHT: timer decrements by 1 each frame.
//   When timer==0: round_reset<=1, state<=PLAY. Dwell = CAUGHT_FRAMES frames exactly.
//   Inputs ignored; START_KEY presses do nothing.
//  OVER: key_hit -> START, lives<=LIVES_INIT, win<=0, round_reset<=1 (pellets and score reload).
//  Timer width $clog2(CAUGHT_FRAMES); it never wraps below 0, it holds 0 outside CAUGHT.
//  lives never underflows: it is decremented only from PLAY with lives>=1.
//  Reset asserted mid-CAUGHT or mid-pulse: immediate return to reset values; a pending round_reset
//   is dropped.
//  Unreachable/illegal state encoding: none exists (2-bit, all 4 codes used); default arm -> START.
// STRUCTURE
//  game_pkg: typedef enum logic [1:0] game_state_t {ST_START=2'h0, ST_PLAY=2'h1,
//   ST_CAUGHT=2'h2, ST_OVER=2'h3}; keycode constants KEY_A/KEY_D/KEY_S/KEY_W/KEY_SPACE.
//   ball and the ghosts import the same enum instead of using literal 2'h2/2'h3.
//  Sub-module key_edge_detect (keycode, match value -> one-frame key_hit) reused by the pause/menu
//   logic later. FSM, lives and timer stay flat in this module.
// TESTING
//  T1 Reset, hold keycode=8'h2C for 5 frames -> state 0->1 after 1 frame, exactly one transition,
//     round_reset stays 0.
//  T2 PLAY, lives=3, pulse caught_check 1 frame -> state=2, lives=2. Stays 2 for 120 frames, then
//     round_reset=1 for 1 frame with state=1. caught_check held in that frame -> no new catch.
//  T3 Catch three times -> lives 3->2->1->0, third catch goes directly to state=3, win=0, no
//     round_reset.
//  T4 PLAY, caught_check and game_over_check high same frame -> state=3, win=1, lives unchanged.
//  T5 OVER, press/release/press 8'h2C -> first press: state=0, lives=3, win=0, round_reset 1 frame.
//     Second press -> state=1.
//  T6 Assert Reset at CAUGHT timer=60 -> state=0, lives=3, round_reset=0 asynchronously. After
//     release, 8'h04 keys ignored and only 8'h2C leaves START.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-state encoding and USB HID keycodes used by the sequencer, ball and ghosts.
package game_pkg;

    typedef enum logic [1:0] {
        ST_START  = 2'h0,
        ST_PLAY   = 2'h1,
        ST_CAUGHT = 2'h2,
        ST_OVER   = 2'h3
    } game_state_t;

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

endpackage

// File: rtl/key_edge_detect.sv
// Turns a held keycode into a single-frame hit: fires only on the frame the match value appears.
module key_edge_detect (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] keycode,
    input  logic [7:0] match,
    output logic       key_hit
);

    logic [7:0] key_prev_q;
    logic [7:0] key_prev_d;

    always_comb begin
        key_prev_d = keycode;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_prev_q <= 8'h00;
        end else begin
            key_prev_q <= key_prev_d;
        end
    end

    assign key_hit = (keycode == match) && (key_prev_q != match);

endmodule

// File: rtl/game_state_ctrl.sv
// Pac-Man game sequencer: START/PLAY/CAUGHT/OVER, lives, post-catch freeze and round_reset pulse.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int         LIVES_INIT    = 3,
    parameter int         CAUGHT_FRAMES = 120,
    parameter logic [7:0] START_KEY     = KEY_SPACE
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       caught_check,
    input  logic       game_over_check,
    output logic [1:0] state,
    output logic [1:0] lives,
    output logic       round_reset,
    output logic       win
);

    localparam int            TW         = $clog2(CAUGHT_FRAMES);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(CAUGHT_FRAMES - 1);
    localparam logic [1:0]    LIVES_LOAD = 2'(LIVES_INIT);

    game_state_t   state_q, state_d;
    logic [1:0]    lives_q, lives_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          round_reset_q, round_reset_d;
    logic          win_q, win_d;
    logic          key_hit;

    key_edge_detect u_key_edge (
        .clk     (frame_clk),
        .rst     (Reset),
        .keycode (keycode),
        .match   (START_KEY),
        .key_hit (key_hit)
    );

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_START;
            lives_q       <= LIVES_LOAD;
            timer_q       <= '0;
            round_reset_q <= 1'b0;
            win_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            timer_q       <= timer_d;
            round_reset_q <= round_reset_d;
            win_q         <= win_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        lives_d       = lives_q;
        timer_d       = timer_q;
        win_d         = win_q;
        round_reset_d = 1'b0;
        case (state_q)
            ST_START: begin
                if (key_hit) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // The frame carrying round_reset is a guard: sprites are still being repositioned.
                if (!round_reset_q) begin
                    if (game_over_check) begin
                        state_d = ST_OVER;
                        win_d   = 1'b1;
                    end else if (caught_check) begin
                        if (lives_q > 2'd1) begin
                            state_d = ST_CAUGHT;
                            lives_d = lives_q - 2'd1;
                            timer_d = TIMER_LOAD;
                        end else begin
                            state_d = ST_OVER;
                            lives_d = 2'd0;
                            win_d   = 1'b0;
                        end
                    end
                end
            end
            ST_CAUGHT: begin
                if (timer_q == '0) begin
                    state_d       = ST_PLAY;
                    round_reset_d = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_OVER: begin
                if (key_hit) begin
                    state_d       = ST_START;
                    lives_d       = LIVES_LOAD;
                    win_d         = 1'b0;
                    round_reset_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_START;
            end
        endcase
    end

    always_comb begin
        state       = state_q;
        lives       = lives_q;
        round_reset = round_reset_q;
        win         = win_q;
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Table-driven, hand-sequenced and randomized checks of game_state_ctrl against expected values.
module tb_game_state_ctrl;

    localparam int CF = 120;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic       caught_check;
    logic       game_over_check;
    logic [1:0] state;
    logic [1:0] lives;
    logic       round_reset;
    logic       win;

    int vectors     = 0;
    int miscompares = 0;

    game_state_ctrl #(
        .LIVES_INIT    (3),
        .CAUGHT_FRAMES (CF),
        .START_KEY     (8'h2C)
    ) dut (
        .frame_clk       (frame_clk),
        .Reset           (Reset),
        .keycode         (keycode),
        .caught_check    (caught_check),
        .game_over_check (game_over_check),
        .state           (state),
        .lives           (lives),
        .round_reset     (round_reset),
        .win             (win)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic [7:0] kc;
        logic       cc;
        logic       go;
        logic [1:0] st;
        logic [1:0] lv;
        logic       rr;
        logic       wn;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] kc, input logic cc, input logic go,
                       input logic [1:0] st, input logic [1:0] lv, input logic rr, input logic wn);
        vec_t v;
        v.kc = kc; v.cc = cc; v.go = go; v.st = st; v.lv = lv; v.rr = rr; v.wn = wn;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [1:0] st, input logic [1:0] lv,
                         input logic rr, input logic wn);
        vectors++;
        if (state !== st || lives !== lv || round_reset !== rr || win !== wn) begin
            miscompares++;
            $display("FAIL %s: got state=%0d lives=%0d rr=%0b win=%0b, want state=%0d lives=%0d rr=%0b win=%0b",
                     name, state, lives, round_reset, win, st, lv, rr, wn);
        end else begin
            $display("ok   %s: state=%0d lives=%0d rr=%0b win=%0b", name, state, lives, round_reset, win);
        end
    endtask

    task automatic apply(input string name, input logic [7:0] kc, input logic cc, input logic go,
                         input logic [1:0] st, input logic [1:0] lv, input logic rr, input logic wn);
        keycode         = kc;
        caught_check    = cc;
        game_over_check = go;
        @(posedge frame_clk);
        #1;
        check(name, st, lv, rr, wn);
    endtask

    // Full freeze after a catch: 119 more frames in CAUGHT (inputs ignored), then the release frame.
    task automatic run_freeze(input logic [1:0] lv);
        for (int i = 0; i < CF - 1; i++) begin
            if (i % 40 == 10) apply("freeze_ignore", 8'h2C, 1'b1, 1'b1, 2'd2, lv, 1'b0, 1'b0);
            else              apply("freeze_dwell", 8'h00, 1'b0, 1'b0, 2'd2, lv, 1'b0, 1'b0);
        end
        apply("freeze_exit", 8'h00, 1'b0, 1'b0, 2'd1, lv, 1'b1, 1'b0);
    endtask

    // Reference model: game modes by name, freeze measured as frames already spent frozen.
    int   m_mode;
    int   m_lives;
    int   m_frozen;
    bit   m_pulse;
    bit   m_win;
    logic [7:0] m_last_key;

    task automatic model_reset();
        m_mode = 0; m_lives = 3; m_frozen = 0; m_pulse = 0; m_win = 0; m_last_key = 8'h00;
    endtask

    task automatic model_step(input logic [7:0] kc, input logic cc, input logic go);
        bit hit;
        bit guard;
        hit        = (kc == 8'h2C) && (m_last_key != 8'h2C);
        m_last_key = kc;
        guard      = m_pulse;
        m_pulse    = 0;
        if (m_mode == 0) begin
            if (hit) m_mode = 1;
        end else if (m_mode == 1) begin
            if (!guard && go) begin
                m_mode = 3; m_win = 1;
            end else if (!guard && cc && m_lives == 1) begin
                m_mode = 3; m_lives = 0; m_win = 0;
            end else if (!guard && cc) begin
                m_mode = 2; m_lives = m_lives - 1; m_frozen = 1;
            end
        end else if (m_mode == 2) begin
            if (m_frozen == CF) begin
                m_mode = 1; m_pulse = 1;
            end else begin
                m_frozen = m_frozen + 1;
            end
        end else begin
            if (hit) begin
                m_mode = 0; m_lives = 3; m_win = 0; m_pulse = 1;
            end
        end
    endtask

    initial begin
        Reset = 1'b1; keycode = 8'h00; caught_check = 1'b0; game_over_check = 1'b0;
        #2;
        check("reset_state", 2'd0, 2'd3, 1'b0, 1'b0);
        @(posedge frame_clk); #1;
        Reset = 1'b0;

        // T1: hold start key 5 frames; T4 simultaneous catch/game-over; T5 restart from OVER.
        for (int i = 0; i < 5; i++) add(8'h2C, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0);
        add(8'h00, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0);
        add(8'h2C, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0);
        add(8'h00, 1'b1, 1'b1, 2'd3, 2'd3, 1'b0, 1'b1);
        add(8'h04, 1'b0, 1'b0, 2'd3, 2'd3, 1'b0, 1'b1);
        add(8'h2C, 1'b0, 1'b0, 2'd0, 2'd3, 1'b1, 1'b0);
        add(8'h00, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0);
        add(8'h2C, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0);
        foreach (tbl[i]) apply("table", tbl[i].kc, tbl[i].cc, tbl[i].go,
                               tbl[i].st, tbl[i].lv, tbl[i].rr, tbl[i].wn);

        // T2 / T3: three catches, guard frames after each freeze.
        apply("catch1", 8'h00, 1'b1, 1'b0, 2'd2, 2'd2, 1'b0, 1'b0);
        run_freeze(2'd2);
        apply("guard1", 8'h00, 1'b1, 1'b0, 2'd1, 2'd2, 1'b0, 1'b0);
        apply("catch2", 8'h00, 1'b1, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0);
        run_freeze(2'd1);
        apply("guard2", 8'h00, 1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0);
        apply("catch3", 8'h00, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0);
        apply("over_hold", 8'h00, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0);
        apply("restart", 8'h2C, 1'b0, 1'b0, 2'd0, 2'd3, 1'b1, 1'b0);
        apply("restart_rel", 8'h00, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0);
        apply("start_again", 8'h2C, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0);

        // T6: asynchronous reset with the freeze timer at 60.
        apply("t6_catch", 8'h00, 1'b1, 1'b0, 2'd2, 2'd2, 1'b0, 1'b0);
        for (int i = 0; i < 59; i++) apply("t6_dwell", 8'h00, 1'b0, 1'b0, 2'd2, 2'd2, 1'b0, 1'b0);
        #2;
        Reset = 1'b1;
        #1;
        check("t6_async_reset", 2'd0, 2'd3, 1'b0, 1'b0);
        @(posedge frame_clk); #1;
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) apply("t6_other_key", 8'h04, 1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0);
        apply("t6_start", 8'h2C, 1'b0, 1'b0, 2'd1, 2'd3, 1'b0, 1'b0);

        // Randomized frames against the reference model.
        #2;
        Reset = 1'b1;
        @(posedge frame_clk); #1;
        Reset = 1'b0;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] kc;
            logic       cc;
            logic       go;
            int         r;
            r  = int'($urandom_range(0, 15));
            kc = (r < 6) ? 8'h2C : ((r < 9) ? 8'h04 : 8'h00);
            cc = ($urandom_range(0, 5) == 0);
            go = ($urandom_range(0, 40) == 0);
            model_step(kc, cc, go);
            apply("random", kc, cc, go, 2'(m_mode), 2'(m_lives), m_pulse, m_win);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
